// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus transaction sequencer.
package rtc_bus_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_A_SETUP  = 4'd1,
      ST_A_STROBE = 4'd2,
      ST_A_HOLD   = 4'd3,
      ST_D_SETUP  = 4'd4,
      ST_D_STROBE = 4'd5,
      ST_D_HOLD   = 4'd6,
      ST_GAP      = 4'd7,
      ST_DONE     = 4'd8
   } rtc_state_e;

   localparam int RTC_SETUP  = 2;
   localparam int RTC_STROBE = 4;
   localparam int RTC_HOLD   = 2;
   localparam int RTC_GAP    = 4;

   localparam logic RTC_RD = 1'b0;
   localparam logic RTC_WR = 1'b1;

   // Counter only ever holds (duration-1), so clog2 of the largest duration suffices.
   function automatic int timer_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter that times each bus-cycle state; stops at zero.
module phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (value != '0) begin
         value <= value - W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Turns single-byte read/write requests into the RTC chip's address-then-data
// bus cycle with timed setup/strobe/hold, registered strobes and a tri-stated AD bus.
module rtc_bus_ctrl
   import rtc_bus_pkg::*;
#(
   parameter int SETUP  = RTC_SETUP,
   parameter int STROBE = RTC_STROBE,
   parameter int HOLD   = RTC_HOLD,
   parameter int GAP    = RTC_GAP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       wr,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       done,
   output logic       busy,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ad_n,
   inout  wire  [7:0] ad
);

   localparam int CW = timer_width(SETUP, STROBE, HOLD, GAP);
   localparam logic [CW-1:0] SETUP_M1  = CW'(SETUP - 1);
   localparam logic [CW-1:0] STROBE_M1 = CW'(STROBE - 1);
   localparam logic [CW-1:0] HOLD_M1   = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_M1    = CW'(GAP - 1);

   rtc_state_e     state, next_state;
   logic           t_load, t_zero;
   logic [CW-1:0]  t_load_value, t_value_unused;
   logic           wr_q;
   logic [7:0]     addr_q, wdata_q;
   logic           ad_oe;
   logic [7:0]     ad_q;

   logic           wr_cur, addr_phase, data_phase;
   logic [7:0]     addr_cur, wdata_cur;
   logic           cs_n_d, rd_n_d, wr_n_d, ad_n_d, ad_oe_d, busy_d, done_d;
   logic [7:0]     ad_d;

   phase_timer #(.W(CW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (t_load),
      .load_value (t_load_value),
      .value      (t_value_unused),
      .zero       (t_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state   = state;
      t_load       = 1'b0;
      t_load_value = '0;
      case (state)
         ST_IDLE:     if (req)    begin next_state = ST_A_SETUP;  t_load = 1'b1; t_load_value = SETUP_M1;  end
         ST_A_SETUP:  if (t_zero) begin next_state = ST_A_STROBE; t_load = 1'b1; t_load_value = STROBE_M1; end
         ST_A_STROBE: if (t_zero) begin next_state = ST_A_HOLD;   t_load = 1'b1; t_load_value = HOLD_M1;   end
         ST_A_HOLD:   if (t_zero) begin next_state = ST_D_SETUP;  t_load = 1'b1; t_load_value = SETUP_M1;  end
         ST_D_SETUP:  if (t_zero) begin next_state = ST_D_STROBE; t_load = 1'b1; t_load_value = STROBE_M1; end
         ST_D_STROBE: if (t_zero) begin next_state = ST_D_HOLD;   t_load = 1'b1; t_load_value = HOLD_M1;   end
         ST_D_HOLD:   if (t_zero) begin next_state = ST_GAP;      t_load = 1'b1; t_load_value = GAP_M1;    end
         ST_GAP:      if (t_zero) next_state = ST_DONE;
         ST_DONE:     next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // Pins are computed from the next state so they change on the same edge as the state.
   always_comb begin
      wr_cur     = (state == ST_IDLE) ? wr    : wr_q;
      addr_cur   = (state == ST_IDLE) ? addr  : addr_q;
      wdata_cur  = (state == ST_IDLE) ? wdata : wdata_q;
      addr_phase = (next_state inside {ST_A_SETUP, ST_A_STROBE, ST_A_HOLD});
      data_phase = (next_state inside {ST_D_SETUP, ST_D_STROBE, ST_D_HOLD});
      cs_n_d     = !(addr_phase || data_phase);
      ad_n_d     = !addr_phase;
      wr_n_d     = !((next_state == ST_A_STROBE) ||
                     ((next_state == ST_D_STROBE) && (wr_cur == RTC_WR)));
      rd_n_d     = !((next_state == ST_D_STROBE) && (wr_cur == RTC_RD));
      ad_oe_d    = addr_phase || (data_phase && (wr_cur == RTC_WR));
      ad_d       = addr_phase ? addr_cur : wdata_cur;
      busy_d     = (next_state != ST_IDLE);
      done_d     = (next_state == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_n  <= 1'b1;
         rd_n  <= 1'b1;
         wr_n  <= 1'b1;
         ad_n  <= 1'b1;
         ad_oe <= 1'b0;
         ad_q  <= 8'h00;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         cs_n  <= cs_n_d;
         rd_n  <= rd_n_d;
         wr_n  <= wr_n_d;
         ad_n  <= ad_n_d;
         ad_oe <= ad_oe_d;
         ad_q  <= ad_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= RTC_RD;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
      end else if ((state == ST_IDLE) && req) begin
         wr_q    <= wr;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // Sampled while rd_n is still low, on the final strobe cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 8'h00;
      end else if ((state == ST_D_STROBE) && t_zero && (wr_q == RTC_RD)) begin
         rdata <= ad;
      end
   end

   assign ad = ad_oe ? ad_q : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: a per-cycle timeline model of the bus cycle
// checks pins, bus value and rdata for a default and an all-ones-timing instance.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;

   logic [7:0] rdata, f_rdata;
   logic       done, busy, cs_n, rd_n, wr_n, ad_n;
   logic       f_done, f_busy, f_cs_n, f_rd_n, f_wr_n, f_ad_n;
   wire  [7:0] ad, f_ad;

   logic       cur_rd = 1'b0;
   logic [7:0] cur_rbyte = 8'h00;
   logic       sel = 1'b0;
   int         p_s = 2, p_st = 4, p_h = 2, p_g = 4;
   logic [7:0] exp_rdata = 8'h00;
   int         n_cmp = 0;
   int         n_fail = 0;

   wire [5:0]  o_pins;
   wire [7:0]  o_ad, o_rdata;

   always #5 clk = ~clk;

   rtc_bus_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .done(done), .busy(busy), .cs_n(cs_n), .rd_n(rd_n),
      .wr_n(wr_n), .ad_n(ad_n), .ad(ad)
   );

   rtc_bus_ctrl #(.SETUP(1), .STROBE(1), .HOLD(1), .GAP(1)) dut_f (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(f_rdata), .done(f_done), .busy(f_busy), .cs_n(f_cs_n), .rd_n(f_rd_n),
      .wr_n(f_wr_n), .ad_n(f_ad_n), .ad(f_ad)
   );

   // Bus model: drives the read byte while rd_n is low and 8'h00 whenever the DUT should float.
   assign ad   = (cur_rd ? ad_n : cs_n) ? ((rd_n == 1'b0) ? cur_rbyte : 8'h00) : 8'hzz;
   assign f_ad = (cur_rd ? f_ad_n : f_cs_n) ? ((f_rd_n == 1'b0) ? cur_rbyte : 8'h00) : 8'hzz;

   assign o_pins  = sel ? {f_busy, f_done, f_cs_n, f_rd_n, f_wr_n, f_ad_n}
                        : {busy, done, cs_n, rd_n, wr_n, ad_n};
   assign o_ad    = sel ? f_ad : ad;
   assign o_rdata = sel ? f_rdata : rdata;

   // {busy, done, cs_n, rd_n, wr_n, ad_n} in cycle k after acceptance.
   function automatic logic [5:0] exp_pins(input int k, input logic w);
      int t, j;
      logic stb;
      t = p_s + p_st + p_h;
      if (k >= 1 && k <= t) begin
         j = k - 1;
         stb = (j >= p_s) && (j < p_s + p_st);
         return {1'b1, 1'b0, 1'b0, 1'b1, !stb, 1'b0};
      end
      if (k > t && k <= 2 * t) begin
         j = k - t - 1;
         stb = (j >= p_s) && (j < p_s + p_st);
         return {1'b1, 1'b0, 1'b0, w ? 1'b1 : !stb, w ? !stb : 1'b1, 1'b1};
      end
      if (k > 2 * t && k <= 2 * t + p_g) return 6'b10_1111;
      if (k == 2 * t + p_g + 1) return 6'b11_1111;
      return 6'b00_1111;
   endfunction

   function automatic logic [7:0] exp_bus(input int k, input logic w, input logic [7:0] a,
                                          input logic [7:0] d, input logic [7:0] rb);
      int t, j;
      t = p_s + p_st + p_h;
      if (k >= 1 && k <= t) return a;
      if (k > t && k <= 2 * t) begin
         if (w) return d;
         j = k - t - 1;
         return ((j >= p_s) && (j < p_s + p_st)) ? rb : 8'h00;
      end
      return 8'h00;
   endfunction

   task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rb_in, input int mode, input int abort_at);
      int t, dd;
      logic [7:0] rb, rd_old, er;
      logic [5:0] ep;
      t  = p_s + p_st + p_h;
      dd = 2 * t + p_g + 1;
      rb = (rb_in != 8'h00) ? rb_in : 8'($urandom_range(1, 255));
      rd_old = exp_rdata;
      @(negedge clk);
      req = 1'b1; wr = w; addr = a; wdata = d;
      cur_rd = !w; cur_rbyte = rb;
      @(posedge clk);
      for (int k = 1; k <= dd; k++) begin
         @(negedge clk);
         ep = exp_pins(k, w);
         n_cmp++;
         if (o_pins !== ep) begin
            n_fail++;
            $display("FAIL pins k=%0d: got %b expected %b (busy,done,cs_n,rd_n,wr_n,ad_n)", k, o_pins, ep);
         end
         n_cmp++;
         if (o_ad !== exp_bus(k, w, a, d, rb)) begin
            n_fail++;
            $display("FAIL ad k=%0d: got %h expected %h", k, o_ad, exp_bus(k, w, a, d, rb));
         end
         er = (!w && k >= t + p_s + p_st + 1) ? rb : rd_old;
         n_cmp++;
         if (o_rdata !== er) begin
            n_fail++;
            $display("FAIL rdata k=%0d: got %h expected %h", k, o_rdata, er);
         end
         if (k == abort_at) begin
            #2 reset = 1'b1;
            #1;
            n_cmp++;
            if (o_pins !== 6'b00_1111 || o_ad !== 8'h00 || o_rdata !== 8'h00) begin
               n_fail++;
               $display("FAIL abort_now: got pins %b ad %h rdata %h expected 001111 00 00", o_pins, o_ad, o_rdata);
            end
            exp_rdata = 8'h00;
            req = 1'b0;
            repeat (2) begin
               @(negedge clk);
               n_cmp++;
               if (o_pins !== 6'b00_1111) begin
                  n_fail++;
                  $display("FAIL abort_hold: got %b expected 001111", o_pins);
               end
            end
            reset = 1'b0;
            return;
         end
         addr = 8'($urandom); wdata = 8'($urandom); wr = 1'($urandom);
         case (mode)
            1:       req = 1'($urandom_range(0, 1));
            2:       req = 1'b1;
            default: req = 1'b0;
         endcase
      end
      if (!w) exp_rdata = rb;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         n_cmp++;
         if (o_pins !== 6'b00_1111 || o_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL idle: got pins %b rdata %h expected 001111 %h", o_pins, o_rdata, exp_rdata);
         end
         req = 1'b0;
      end
   endtask

   task automatic test_reset();
      exp_rdata = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (o_pins !== 6'b00_1111 || o_ad !== 8'h00 || o_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_vals: got pins %b ad %h rdata %h expected 001111 00 00", o_pins, o_ad, o_rdata);
      end
      reset = 1'b0;
      idle(3);
   endtask

   task automatic test_write();
      run_txn(1'b1, 8'h21, 8'h55, 8'h00, 0, 0);
      idle(2);
   endtask

   task automatic test_read();
      run_txn(1'b0, 8'h22, 8'h00, 8'h37, 0, 0);
      idle(1);
      run_txn(1'b1, 8'h40, 8'hA5, 8'h00, 0, 0);
      idle(1);
   endtask

   task automatic test_ignore_req();
      run_txn(1'b1, 8'h10, 8'h3C, 8'h00, 1, 0);
      idle(3);
      run_txn(1'b0, 8'h11, 8'h00, 8'h00, 1, 0);
      idle(3);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'h00, 2, 0);
      idle(3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'h00, $urandom_range(0, 2), 0);
         idle($urandom_range(0, 3));
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      run_txn(1'b0, 8'h33, 8'h00, 8'h00, 0, 0);
      idle(1);
      run_txn(1'b1, 8'h34, 8'h55, 8'h00, 0, (p_s + p_st + p_h) + p_s + 2);
      idle(2);
      run_txn(1'b0, 8'h35, 8'h00, 8'h00, 0, 0);
      idle(2);
   endtask

   task automatic test_fast();
      @(negedge clk);
      reset = 1'b1;
      req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      sel = 1'b1;
      p_s = 1; p_st = 1; p_h = 1; p_g = 1;
      exp_rdata = 8'h00;
      idle(2);
      run_txn(1'b1, 8'h21, 8'h55, 8'h00, 0, 0);
      idle(1);
      run_txn(1'b0, 8'h22, 8'h00, 8'h37, 0, 0);
      idle(1);
      for (int i = 0; i < 5; i++) begin
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'h00, $urandom_range(0, 2), 0);
         idle($urandom_range(0, 2));
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_ignore_req();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_fast();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
